// File: rtl/inst_mem_sync_if.sv
// rtl/inst_mem_sync_if.sv - loader and fetch bus between the IF stage/loader and inst_mem_sync
interface inst_mem_sync_if #(
    parameter int ADDR_W = 64
);
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              ld_done;
    logic              fetch_req;
    logic [ADDR_W-1:0] Instr_Addr;
    logic              stall;
    logic              flush;
    logic [31:0]       Instruction;
    logic              instr_valid;
    logic              run_mode;
    logic [15:0]       ld_count;
    logic              fetch_fault;

    modport master (
        output ld_we, ld_addr, ld_data, ld_done,
        output fetch_req, Instr_Addr, stall, flush,
        input  Instruction, instr_valid, run_mode, ld_count, fetch_fault
    );

    modport slave (
        input  ld_we, ld_addr, ld_data, ld_done,
        input  fetch_req, Instr_Addr, stall, flush,
        output Instruction, instr_valid, run_mode, ld_count, fetch_fault
    );
endinterface

// File: rtl/inst_mem_sync.sv
// rtl/inst_mem_sync.sv - byte-addressed instruction memory with LOAD/RUN FSM and registered fetch.
// Optional fetch/load range checking is enabled by defining IMEM_BOUNDS_CHECK_EN.
module inst_mem_sync #(
    parameter int          ADDR_W      = 64,
    parameter int          DEPTH_BYTES = 256,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic           clk,
    input  logic           reset,
    inst_mem_sync_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        fault_q;
    logic [15:0] ld_count_q;
    logic [15:0] ld_count_d;

    logic [7:0]  mem_q [DEPTH_BYTES];

    logic [IDX_W-1:0] ld_idx0, ld_idx1, ld_idx2, ld_idx3;
    logic [IDX_W-1:0] f_idx0, f_idx1, f_idx2, f_idx3;
    logic [31:0]      fetch_word;
    logic             ld_bad;
    logic             fetch_bad;
    logic             ld_accept;
    logic             unused_addr_bits;

    // Byte indices wrap naturally because they are exactly IDX_W bits wide.
    assign ld_idx0 = bus.ld_addr[IDX_W-1:0];
    assign ld_idx1 = ld_idx0 + IDX_W'(1);
    assign ld_idx2 = ld_idx0 + IDX_W'(2);
    assign ld_idx3 = ld_idx0 + IDX_W'(3);
    assign f_idx0  = bus.Instr_Addr[IDX_W-1:0];
    assign f_idx1  = f_idx0 + IDX_W'(1);
    assign f_idx2  = f_idx0 + IDX_W'(2);
    assign f_idx3  = f_idx0 + IDX_W'(3);

    assign fetch_word       = {mem_q[f_idx3], mem_q[f_idx2], mem_q[f_idx1], mem_q[f_idx0]};
    assign unused_addr_bits = ^{bus.ld_addr[ADDR_W-1:IDX_W], bus.Instr_Addr[ADDR_W-1:IDX_W]};

`ifdef IMEM_BOUNDS_CHECK_EN
    // One extra bit keeps addr+3 from wrapping at the top of the address space.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) ||
               (({1'b0, a} + (ADDR_W+1)'(3)) >= (ADDR_W+1)'(DEPTH_BYTES));
    endfunction

    assign ld_bad    = out_of_range(bus.ld_addr);
    assign fetch_bad = out_of_range(bus.Instr_Addr);
`else
    assign ld_bad    = 1'b0;
    assign fetch_bad = 1'b0;
`endif

    assign ld_accept  = (state_q == S_LOAD) && bus.ld_we && !ld_bad;
    assign ld_count_d = (ld_count_q == 16'hFFFF) ? ld_count_q : ld_count_q + 16'd1;

    // Contents survive reset; only the write strobe is gated by it.
    always_ff @(posedge clk) begin
        if (!reset && ld_accept) begin
            mem_q[ld_idx0] <= bus.ld_data[7:0];
            mem_q[ld_idx1] <= bus.ld_data[15:8];
            mem_q[ld_idx2] <= bus.ld_data[23:16];
            mem_q[ld_idx3] <= bus.ld_data[31:24];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_LOAD;
            instr_q    <= NOP_WORD;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            ld_count_q <= 16'd0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    instr_q <= NOP_WORD;
                    valid_q <= 1'b0;
                    fault_q <= 1'b0;
                    if (ld_accept) begin
                        ld_count_q <= ld_count_d;
                    end
                    if (bus.ld_done) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.flush) begin
                        instr_q <= NOP_WORD;
                        valid_q <= 1'b0;
                        fault_q <= 1'b0;
                    end else if (!bus.stall) begin
                        if (bus.fetch_req && fetch_bad) begin
                            instr_q <= NOP_WORD;
                            valid_q <= 1'b1;
                            fault_q <= 1'b1;
                        end else if (bus.fetch_req) begin
                            instr_q <= fetch_word;
                            valid_q <= 1'b1;
                            fault_q <= 1'b0;
                        end else begin
                            instr_q <= NOP_WORD;
                            valid_q <= 1'b0;
                            fault_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign bus.Instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.run_mode    = (state_q == S_RUN);
    assign bus.ld_count    = ld_count_q;
    assign bus.fetch_fault = fault_q;
endmodule

// File: tb/tb_inst_mem_sync.sv
// tb/tb_inst_mem_sync.sv - directed vector bench for inst_mem_sync (honours IMEM_BOUNDS_CHECK_EN)
module tb_inst_mem_sync;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    inst_mem_sync_if #(.ADDR_W(64)) bus ();

    inst_mem_sync #(
        .ADDR_W     (64),
        .DEPTH_BYTES(256),
        .NOP_WORD   (NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        we;
        logic [63:0] la;
        logic [31:0] ld;
        logic        done;
        logic        fr;
        logic [63:0] fa;
        logic        st;
        logic        fl;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_run;
        logic [15:0] e_cnt;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, we, input logic [63:0] la, input logic [31:0] ld,
                       input logic done, fr, input logic [63:0] fa, input logic st, fl,
                       input logic [31:0] ei, input logic ev, er, input logic [15:0] ec,
                       input logic ef);
        vec_t v;
        v.rst = rst; v.we = we; v.la = la; v.ld = ld; v.done = done;
        v.fr = fr; v.fa = fa; v.st = st; v.fl = fl;
        v.e_instr = ei; v.e_valid = ev; v.e_run = er; v.e_cnt = ec; v.e_fault = ef;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, we, input logic [63:0] la, input logic [31:0] ld,
                         input logic done, fr, input logic [63:0] fa, input logic st, fl);
        reset          = rst;
        bus.ld_we      = we;
        bus.ld_addr    = la;
        bus.ld_data    = ld;
        bus.ld_done    = done;
        bus.fetch_req  = fr;
        bus.Instr_Addr = fa;
        bus.stall      = st;
        bus.flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int tag, input logic [31:0] got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%h exp=%h", nm, tag, got, exp);
        end
    endtask

    task automatic chk_all(input int tag, input logic [31:0] ei, input logic ev, er,
                           input logic [15:0] ec, input logic ef);
        chk("instr", tag, bus.Instruction, ei);
        chk("valid", tag, {31'd0, bus.instr_valid}, {31'd0, ev});
        chk("run_mode", tag, {31'd0, bus.run_mode}, {31'd0, er});
        chk("ld_count", tag, {16'd0, bus.ld_count}, {16'd0, ec});
        chk("fault", tag, {31'd0, bus.fetch_fault}, {31'd0, ef});
    endtask

    task automatic step(input int tag, input logic rst, we, input logic [63:0] la,
                        input logic [31:0] ld, input logic done, fr, input logic [63:0] fa,
                        input logic st, fl, input logic [31:0] ei, input logic ev, er,
                        input logic [15:0] ec, input logic ef);
        drive(rst, we, la, ld, done, fr, fa, st, fl);
        tick();
        chk_all(tag, ei, ev, er, ec, ef);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //   rst we la      ld            done fr fa      st fl  instr         v  run cnt fault
        add(1, 1, 64'h0, 32'hFFFFFFFF, 1, 1, 64'h0, 0, 0, NOP,          0, 0, 0, 0);
        add(1, 0, 64'h0, 32'h0,        0, 0, 64'h0, 0, 0, NOP,          0, 0, 0, 0);
        add(0, 1, 64'h0, 32'h10000A13, 0, 1, 64'h0, 0, 0, NOP,          0, 0, 1, 0);
        add(0, 1, 64'h4, 32'h03700A93, 1, 1, 64'h0, 0, 0, NOP,          0, 1, 2, 0);
        add(0, 0, 64'h0, 32'h0,        0, 1, 64'h0, 0, 0, 32'h10000A13, 1, 1, 2, 0);
        add(0, 0, 64'h0, 32'h0,        0, 1, 64'h4, 0, 0, 32'h03700A93, 1, 1, 2, 0);
        add(0, 0, 64'h0, 32'h0,        0, 0, 64'h0, 0, 0, NOP,          0, 1, 2, 0);
        add(0, 1, 64'h0, 32'hDEADBEEF, 0, 0, 64'h0, 0, 0, NOP,          0, 1, 2, 0);
        add(0, 0, 64'h0, 32'h0,        0, 1, 64'h0, 0, 0, 32'h10000A13, 1, 1, 2, 0);
        add(0, 0, 64'h0, 32'h0,        0, 1, 64'h4, 0, 0, 32'h03700A93, 1, 1, 2, 0);
        add(0, 0, 64'h0, 32'h0,        0, 1, 64'h0, 1, 0, 32'h03700A93, 1, 1, 2, 0);
        add(0, 0, 64'h0, 32'h0,        0, 1, 64'h0, 1, 0, 32'h03700A93, 1, 1, 2, 0);
        add(0, 0, 64'h0, 32'h0,        0, 1, 64'h0, 1, 0, 32'h03700A93, 1, 1, 2, 0);
        add(0, 0, 64'h0, 32'h0,        0, 1, 64'h0, 1, 1, NOP,          0, 1, 2, 0);
        add(0, 0, 64'h0, 32'h0,        0, 1, 64'h0, 0, 0, 32'h10000A13, 1, 1, 2, 0);
        add(1, 1, 64'h0, 32'hDEADBEEF, 1, 1, 64'h0, 0, 0, NOP,          0, 0, 0, 0);
        add(0, 0, 64'h0, 32'h0,        1, 1, 64'h0, 0, 0, NOP,          0, 1, 0, 0);
        add(0, 0, 64'h0, 32'h0,        0, 1, 64'h0, 0, 0, 32'h10000A13, 1, 1, 0, 0);
        add(0, 0, 64'h0, 32'h0,        0, 1, 64'h4, 0, 0, 32'h03700A93, 1, 1, 0, 0);
        add(0, 0, 64'h0, 32'h0,        0, 1, 64'h4, 0, 1, NOP,          0, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i].rst, vecs[i].we, vecs[i].la, vecs[i].ld, vecs[i].done,
                 vecs[i].fr, vecs[i].fa, vecs[i].st, vecs[i].fl,
                 vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_run, vecs[i].e_cnt, vecs[i].e_fault);
        end

        // Top-of-memory load and wrap/range behaviour
        step(100, 1, 0, 64'h0,   32'h0,        0, 0, 64'h0, 0, 0, NOP, 0, 0, 0, 0);
        step(101, 0, 1, 64'hFC,  32'h11223344, 0, 0, 64'h0, 0, 0, NOP, 0, 0, 1, 0);
`ifdef IMEM_BOUNDS_CHECK_EN
        step(102, 0, 1, 64'h100, 32'hCAFEF00D, 1, 0, 64'h0, 0, 0, NOP, 0, 1, 1, 0);
        step(103, 0, 0, 64'h0, 32'h0, 0, 1, 64'h102, 0, 0, NOP,          1, 1, 1, 1);
        step(104, 0, 0, 64'h0, 32'h0, 0, 1, 64'hFC,  1, 0, NOP,          1, 1, 1, 1);
        step(105, 0, 0, 64'h0, 32'h0, 0, 1, 64'hFC,  1, 1, NOP,          0, 1, 1, 0);
        step(106, 0, 0, 64'h0, 32'h0, 0, 1, 64'hFC,  0, 0, 32'h11223344, 1, 1, 1, 0);
        step(107, 0, 0, 64'h0, 32'h0, 0, 1, 64'h100, 0, 0, NOP,          1, 1, 1, 1);
        step(108, 0, 0, 64'h0, 32'h0, 0, 1, 64'hFD,  0, 0, NOP,          1, 1, 1, 1);
        step(109, 0, 0, 64'h0, 32'h0, 0, 1, 64'h0,   0, 0, 32'h10000A13, 1, 1, 1, 0);
`else
        step(102, 0, 1, 64'h100, 32'h10000A13, 1, 0, 64'h0, 0, 0, NOP, 0, 1, 2, 0);
        step(103, 0, 0, 64'h0, 32'h0, 0, 1, 64'h100, 0, 0, 32'h10000A13, 1, 1, 2, 0);
        step(104, 0, 0, 64'h0, 32'h0, 0, 1, 64'hFE,  0, 0, 32'h0A131122, 1, 1, 2, 0);
        step(105, 0, 0, 64'h0, 32'h0, 0, 1, 64'hFC,  0, 0, 32'h11223344, 1, 1, 2, 0);
        step(106, 0, 0, 64'h0, 32'h0, 0, 1, 64'h104, 0, 0, 32'h03700A93, 1, 1, 2, 0);
        step(107, 0, 0, 64'h0, 32'h0, 0, 1, 64'h1FC, 1, 0, 32'h03700A93, 1, 1, 2, 0);
`endif

        // ld_count saturation
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 64'h0, 32'h10000A13, 0, 0, 64'h0, 0, 0);
        for (int n = 0; n < 65535; n++) begin
            tick();
        end
        chk("ld_count_sat", 200, {16'd0, bus.ld_count}, 32'h0000FFFF);
        tick();
        chk("ld_count_hold", 201, {16'd0, bus.ld_count}, 32'h0000FFFF);
        step(202, 0, 1, 64'h0, 32'h10000A13, 1, 0, 64'h0, 0, 0, NOP, 0, 1, 16'hFFFF, 0);
        step(203, 0, 0, 64'h0, 32'h0, 0, 1, 64'h0, 0, 0, 32'h10000A13, 1, 1, 16'hFFFF, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_mem_sync.md
INST_MEM_SYNC -- requirements
Module: inst_mem_sync

Interface
REQ-001 Parameter ADDR_W, default 64, meaning fetch/load address width in bits.
REQ-002 Parameter DEPTH_BYTES, default 256, meaning byte capacity; SHALL be a power of two and at least 4.
REQ-003 Parameter NOP_WORD, default 32'h00000013, meaning word driven when no valid instruction is presented.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ld_we  input  1  loader word-write strobe.
REQ-007 ld_addr  input  ADDR_W  loader byte address, word-aligned.
REQ-008 ld_data  input  32  loader word, stored little-endian (bits 7:0 at ld_addr).
REQ-009 ld_done  input  1  loader completion pulse.
REQ-010 fetch_req  input  1  fetch request from IF stage.
REQ-011 Instr_Addr  input  ADDR_W  fetch byte address (PC).
REQ-012 stall  input  1  hold current output.
REQ-013 flush  input  1  discard the in-flight fetch.
REQ-014 Instruction  output  32  registered instruction word.
REQ-015 instr_valid  output  1  Instruction is valid this cycle.
REQ-016 run_mode  output  1  1 = RUN state, 0 = LOAD state.
REQ-017 ld_count  output  16  number of accepted loader writes since reset, saturating at 16'hFFFF.
REQ-018 fetch_fault  output  1  registered fault flag for the presented word (see Configuration).

Function
REQ-019 Two-state FSM: LOAD (after reset) -> RUN on ld_done=1; RUN is left only by reset.
REQ-020 In LOAD, ld_we=1 SHALL write the 4 bytes at ld_addr..ld_addr+3 (index modulo DEPTH_BYTES) and increment ld_count.
REQ-021 In RUN, ld_we SHALL be ignored: no write, ld_count unchanged.
REQ-022 ld_we and ld_done in the same LOAD cycle: write accepted, then transition to RUN.
REQ-023 In LOAD, fetch_req SHALL be ignored; instr_valid=0 and Instruction=NOP_WORD.
REQ-024 In RUN with stall=0 and flush=0, fetch_req=1 SHALL present bytes Instr_Addr..+3 on Instruction with instr_valid=1 exactly one cycle later.
REQ-025 In RUN, fetch_req=0 with stall=0 and flush=0 SHALL give instr_valid=0 and Instruction=NOP_WORD the next cycle.
REQ-026 stall=1 with flush=0 SHALL hold Instruction, instr_valid and fetch_fault unchanged; fetch_req is ignored.
REQ-027 flush=1 SHALL force instr_valid=0, Instruction=NOP_WORD and fetch_fault=0 the next cycle; flush has priority over stall and fetch_req.
REQ-028 Memory array SHALL be DEPTH_BYTES x 8 bits; byte index = address[log2(DEPTH_BYTES)-1:0]; byte addresses +1..+3 SHALL wrap modulo DEPTH_BYTES.

Reset
REQ-029 While reset=1: state=LOAD, Instruction=NOP_WORD, instr_valid=0, fetch_fault=0, ld_count=0, run_mode=0.
REQ-030 reset SHALL take priority over ld_we, ld_done, fetch_req, stall and flush; a write strobed in a reset cycle SHALL be dropped.
REQ-031 Memory contents SHALL NOT be cleared by reset, including reset asserted mid-load or mid-run.

Configuration
REQ-032 Macro IMEM_BOUNDS_CHECK_EN SHALL control fetch checking.
REQ-033 With IMEM_BOUNDS_CHECK_EN defined, a RUN fetch SHALL be faulted when Instr_Addr[1:0]!=0 or Instr_Addr+3 >= DEPTH_BYTES.
REQ-034 With IMEM_BOUNDS_CHECK_EN defined, a faulted fetch SHALL present fetch_fault=1, instr_valid=1 and Instruction=NOP_WORD after one cycle.
REQ-035 With IMEM_BOUNDS_CHECK_EN defined, a faulted loader write SHALL be dropped and SHALL NOT increment ld_count.
REQ-036 Without IMEM_BOUNDS_CHECK_EN, fetch_fault SHALL be tied 0 and all addresses SHALL wrap per REQ-028.

Verification
REQ-037 Reset, load 0x10000A13 @0 and 0x03700A93 @4, ld_done, fetch 0 then 4 -> 0x10000A13 then 0x03700A93, each one cycle after request, instr_valid=1, ld_count=2.
REQ-038 In RUN, ld_we with 0xDEADBEEF @0 then fetch 0 -> 0x10000A13, ld_count stays 2.
REQ-039 Fetch 4, stall for 3 cycles with Instr_Addr=0 -> Instruction holds 0x03700A93; flush+stall together -> next cycle NOP 0x00000013, instr_valid=0.
REQ-040 Reset asserted mid-run -> next cycle run_mode=0, ld_count=0, NOP output; after ld_done, fetch 0 -> 0x10000A13 (contents retained).
REQ-041 IMEM_BOUNDS_CHECK_EN defined, DEPTH_BYTES=256: fetch 0x102 -> fetch_fault=1, Instruction=0x00000013; fetch 0xFC -> fetch_fault=0; fetch 0x100 -> fetch_fault=1.
REQ-042 IMEM_BOUNDS_CHECK_EN undefined: fetch 0x100 -> same word as fetch 0x000, fetch_fault=0.
